// File: rtl/sparse_block_expander.sv
// sparse_block_expander
// Streaming decompressor: accepts one bitmask per block, then dense beats of
// up to MAX_NUM_INPUT elements. It scatters the elements LSB-first onto the
// set bits of the mask, zero-fills the rest, and presents the sparse block.
//
// Ports:
//   clock, reset                : single clock, synchronous active-high reset
//   ivalidMask / oreadyMask     : mask handshake, bitmask carries the mask
//   ivalidDense / oreadyDense   : dense beat handshake (denseInput, numDenseInput)
//   ovalid / iready             : sparse block handshake
//   sparseOutput, outputMask    : reconstructed block and its mask
//   overflowError               : one-cycle pulse when beat elements are dropped
module sparse_block_expander #(
    parameter int BITMASK_LENGTH = 8,
    parameter int ELEMENT_WIDTH  = 16,
    parameter int MAX_NUM_INPUT  = 2,
    parameter int COUNT_BITWIDTH = 2,
    parameter int INDEX_BITWIDTH = 4
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    ivalidMask,
    output logic                                    oreadyMask,
    input  logic [BITMASK_LENGTH-1:0]               bitmask,
    input  logic                                    ivalidDense,
    output logic                                    oreadyDense,
    input  logic [ELEMENT_WIDTH*MAX_NUM_INPUT-1:0]  denseInput,
    input  logic [COUNT_BITWIDTH-1:0]               numDenseInput,
    output logic                                    ovalid,
    input  logic                                    iready,
    output logic [ELEMENT_WIDTH*BITMASK_LENGTH-1:0] sparseOutput,
    output logic [BITMASK_LENGTH-1:0]               outputMask,
    output logic                                    overflowError
);

    typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

    state_t                              state_q, state_d;
    logic [BITMASK_LENGTH-1:0]           mask_q, mask_d;
    logic [ELEMENT_WIDTH*BITMASK_LENGTH-1:0] data_q, data_d;
    logic [INDEX_BITWIDTH-1:0]           ptr_q, ptr_d;
    logic [INDEX_BITWIDTH-1:0]           rem_q, rem_d;
    logic                                rdy_mask_q, rdy_mask_d;
    logic                                rdy_dense_q, rdy_dense_d;
    logic                                ovalid_q, ovalid_d;
    logic                                ovf_q, ovf_d;

    function automatic logic [INDEX_BITWIDTH-1:0] popcount(input logic [BITMASK_LENGTH-1:0] m);
        logic [INDEX_BITWIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < BITMASK_LENGTH; i++) begin
            c = c + INDEX_BITWIDTH'(m[i]);
        end
        return c;
    endfunction

    always_comb begin
        int clamped;
        int n;
        int k;
        int last;
        state_d = state_q;
        mask_d  = mask_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        ovf_d   = 1'b0;
        clamped = 0;
        n       = 0;
        k       = 0;
        last    = 0;
        case (state_q)
            IDLE: begin
                if (ivalidMask && rdy_mask_q) begin
                    mask_d  = bitmask;
                    data_d  = '0;
                    ptr_d   = '0;
                    rem_d   = popcount(bitmask);
                    state_d = (rem_d == '0) ? EMIT : FILL;
                end
            end
            FILL: begin
                if (ivalidDense && rdy_dense_q) begin
                    clamped = int'(numDenseInput);
                    if (clamped > MAX_NUM_INPUT) clamped = MAX_NUM_INPUT;
                    n = clamped;
                    if (n > int'(rem_q)) n = int'(rem_q);
                    // Walk positions from the pointer, handing element k to
                    // the k-th set bit; last tracks where the pointer resumes.
                    last = int'(ptr_q) - 1;
                    for (int i = 0; i < BITMASK_LENGTH; i++) begin
                        if (i >= int'(ptr_q) && mask_q[i] && k < n) begin
                            data_d[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
                                denseInput[k*ELEMENT_WIDTH +: ELEMENT_WIDTH];
                            k    = k + 1;
                            last = i;
                        end
                    end
                    ptr_d = INDEX_BITWIDTH'(last + 1);
                    rem_d = rem_q - INDEX_BITWIDTH'(n);
                    ovf_d = (clamped > int'(rem_q));
                    if (rem_d == '0) state_d = EMIT;
                end
            end
            EMIT: begin
                if (ovalid_q && iready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered from the next state so no input
        // reaches a ready/valid output combinationally.
        rdy_mask_d  = (state_d == IDLE);
        rdy_dense_d = (state_d == FILL);
        ovalid_d    = (state_d == EMIT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            data_q      <= '0;
            ptr_q       <= '0;
            rem_q       <= '0;
            rdy_mask_q  <= 1'b0;
            rdy_dense_q <= 1'b0;
            ovalid_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            rdy_mask_q  <= rdy_mask_d;
            rdy_dense_q <= rdy_dense_d;
            ovalid_q    <= ovalid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign oreadyMask    = rdy_mask_q;
    assign oreadyDense   = rdy_dense_q;
    assign ovalid        = ovalid_q;
    assign sparseOutput  = data_q;
    assign outputMask    = mask_q;
    assign overflowError = ovf_q;

endmodule

// File: tb/tb_sparse_block_expander.sv
module tb_sparse_block_expander;
    localparam int BL = 8;
    localparam int EW = 16;
    localparam int MX = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          ivalidMask, oreadyMask;
    logic [7:0]    bitmask;
    logic          ivalidDense, oreadyDense;
    logic [31:0]   denseInput;
    logic [1:0]    numDenseInput;
    logic          ovalid, iready;
    logic [127:0]  sparseOutput;
    logic [7:0]    outputMask;
    logic          overflowError;

    sparse_block_expander #(
        .BITMASK_LENGTH(8), .ELEMENT_WIDTH(16), .MAX_NUM_INPUT(2),
        .COUNT_BITWIDTH(2), .INDEX_BITWIDTH(4)
    ) dut (
        .clock(clock), .reset(reset),
        .ivalidMask(ivalidMask), .oreadyMask(oreadyMask), .bitmask(bitmask),
        .ivalidDense(ivalidDense), .oreadyDense(oreadyDense),
        .denseInput(denseInput), .numDenseInput(numDenseInput),
        .ovalid(ovalid), .iready(iready),
        .sparseOutput(sparseOutput), .outputMask(outputMask),
        .overflowError(overflowError)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]        mask;
        logic [2:0]        nb;
        logic [3:0][1:0]   num;
        logic [3:0][31:0]  dat;
        logic [127:0]      exp;
        logic [3:0]        ovf;
    } vec_t;

    vec_t vt[6];

    int          bnum[$];
    logic [31:0] bdat[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: concatenate the first min(num,MAX) elements of every beat,
    // deal them onto the set bits of the mask in order, drop the rest.
    task automatic model(input logic [7:0] m, output logic [127:0] out, output logic [31:0] ovfb);
        logic [15:0] elems[$];
        logic [31:0] w;
        int pop, taken, cl, tk;
        pop = 0; taken = 0; ovfb = '0; out = '0;
        for (int i = 0; i < BL; i++) pop += int'(m[i]);
        for (int b = 0; b < bnum.size(); b++) begin
            w  = bdat[b];
            cl = (bnum[b] > MX) ? MX : bnum[b];
            tk = (cl > pop - taken) ? pop - taken : cl;
            if (cl > pop - taken) ovfb[b] = 1'b1;
            for (int k = 0; k < tk; k++) elems.push_back(w[k*EW +: EW]);
            taken += tk;
        end
        for (int i = 0; i < BL; i++)
            if (m[i]) out[i*EW +: EW] = elems.pop_front();
    endtask

    task automatic run_block(input logic [7:0] m, input int gap_max, input int hold,
                             input bit use_tab, input logic [127:0] texp,
                             input logic [31:0] tovf, output int lat);
        logic [127:0] exp, snap;
        logic [31:0]  ovfb;
        logic [7:0]   msnap;
        bit hs;
        int guard, t0;
        if (use_tab) begin exp = texp; ovfb = tovf; end
        else model(m, exp, ovfb);
        lat = -1;
        ivalidMask = 1'b1; bitmask = m; guard = 0;
        do begin hs = oreadyMask; tick(); guard++; end while (!hs && guard < 50);
        ivalidMask = 1'b0; bitmask = 8'($urandom);
        if (!hs) chk("mask_timeout", 0, 1);
        t0 = cyc;
        for (int b = 0; b < bnum.size(); b++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            ivalidDense = 1'b1; numDenseInput = 2'(bnum[b]); denseInput = bdat[b]; guard = 0;
            do begin hs = oreadyDense; tick(); guard++; end while (!hs && guard < 50);
            ivalidDense = 1'b0; denseInput = $urandom; numDenseInput = 2'($urandom);
            if (!hs) chk("dense_timeout", 0, 1);
            chk("overflow", overflowError, ovfb[b]);
            if (b != bnum.size() - 1) chk("ovalid_early", ovalid, 0);
        end
        lat = cyc - t0 + 1;
        chk("ovalid", ovalid, 1);
        chk("data", sparseOutput, exp);
        chk("outmask", outputMask, m);
        chk("oreadyDense_emit", oreadyDense, 0);
        snap = sparseOutput; msnap = outputMask;
        iready = 1'b0;
        repeat (hold) begin
            tick();
            chk("hold_data", sparseOutput, snap);
            chk("hold_mask", outputMask, msnap);
            chk("hold_ovalid", ovalid, 1);
            chk("hold_rmask", oreadyMask, 0);
            chk("hold_rdense", oreadyDense, 0);
            chk("ovf_clear", overflowError, 0);
        end
        iready = 1'b1;
        tick();
        iready = 1'b0;
        chk("ovalid_drop", ovalid, 0);
        chk("rmask_after", oreadyMask, 1);
        bnum.delete(); bdat.delete();
    endtask

    task automatic setv(input int i, input logic [7:0] m, input logic [2:0] nb,
                        input logic [7:0] num, input logic [127:0] dat,
                        input logic [127:0] exp, input logic [3:0] ovf);
        vt[i].mask = m; vt[i].nb = nb; vt[i].num = num; vt[i].dat = dat;
        vt[i].exp = exp; vt[i].ovf = ovf;
    endtask

    initial begin
        int lat, rem, n, cl, r;
        logic [7:0] m;
        logic [31:0] w;

        setv(0, 8'b1010_0110, 3'd2, {2'd0, 2'd0, 2'd2, 2'd2},
             {32'h0, 32'h0, 32'h0044_0033, 32'h0022_0011},
             128'h0044_0000_0033_0000_0000_0022_0011_0000, 4'b0000);
        setv(1, 8'b0000_0001, 3'd1, {2'd0, 2'd0, 2'd0, 2'd2},
             {32'h0, 32'h0, 32'h0, 32'h00BB_00AA},
             128'h0000_0000_0000_0000_0000_0000_0000_00AA, 4'b0001);
        setv(2, 8'h00, 3'd0, 8'h00, 128'h0, 128'h0, 4'b0000);
        setv(3, 8'hFF, 3'd4, {2'd2, 2'd2, 2'd2, 2'd2},
             {32'h0008_0007, 32'h0006_0005, 32'h0004_0003, 32'h0002_0001},
             128'h0008_0007_0006_0005_0004_0003_0002_0001, 4'b0000);
        setv(4, 8'b1000_0001, 3'd2, {2'd0, 2'd0, 2'd1, 2'd1},
             {32'h0, 32'h0, 32'hBEEF_5678, 32'hDEAD_1234},
             128'h5678_0000_0000_0000_0000_0000_0000_1234, 4'b0000);
        setv(5, 8'b0000_0111, 3'd2, {2'd0, 2'd0, 2'd1, 2'd3},
             {32'h0, 32'h0, 32'hDEAD_000C, 32'h000B_000A},
             128'h0000_0000_0000_0000_0000_000C_000B_000A, 4'b0000);

        reset = 1'b1; ivalidMask = 1'b0; ivalidDense = 1'b0; iready = 1'b0;
        bitmask = '0; denseInput = '0; numDenseInput = '0;
        repeat (3) tick();
        chk("rst_ovalid", ovalid, 0);
        chk("rst_rmask", oreadyMask, 0);
        chk("rst_rdense", oreadyDense, 0);
        chk("rst_ovf", overflowError, 0);
        chk("rst_data", sparseOutput, 0);
        chk("rst_omask", outputMask, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_ovalid", ovalid, 0);
        chk("post_rst_rdense", oreadyDense, 0);
        chk("post_rst_data", sparseOutput, 0);

        // Fixed vectors, back-to-back beats so latency is exact.
        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < int'(vt[i].nb); b++) begin
                bnum.push_back(int'(vt[i].num[b]));
                bdat.push_back(vt[i].dat[b]);
            end
            if (vt[i].nb == 0) begin
                ivalidDense = 1'b1; numDenseInput = 2'd2; denseInput = 32'hFFFF_FFFF;
            end
            run_block(vt[i].mask, 0, 1, 1'b1, vt[i].exp, {28'h0, vt[i].ovf}, lat);
            ivalidDense = 1'b0;
            chk($sformatf("latency_v%0d", i), lat, (vt[i].nb == 0) ? 1 : int'(vt[i].nb) + 1);
        end

        // Gaps with empty beats, then 5 cycles of backpressure.
        bnum = '{1, 0, 2, 0, 1, 2, 0, 2};
        bdat = '{32'hDEAD_0001, 32'hDEAD_DEAD, 32'h0003_0002, 32'hBEEF_BEEF,
                 32'hDEAD_0004, 32'h0006_0005, 32'h1111_2222, 32'h0008_0007};
        run_block(8'hFF, 3, 5, 1'b0, '0, '0, lat);

        // Reset in the middle of a fill.
        ivalidMask = 1'b1; bitmask = 8'h0F;
        tick();
        ivalidMask = 1'b0;
        chk("mf_rdense", oreadyDense, 1);
        ivalidDense = 1'b1; numDenseInput = 2'd1; denseInput = 32'h0000_0BAD;
        tick();
        ivalidDense = 1'b0;
        reset = 1'b1;
        tick();
        chk("mf_rst_ovalid", ovalid, 0);
        chk("mf_rst_data", sparseOutput, 0);
        chk("mf_rst_omask", outputMask, 0);
        chk("mf_rst_rdense", oreadyDense, 0);
        tick();
        reset = 1'b0;
        repeat (3) begin
            tick();
            chk("mf_after_ovalid", ovalid, 0);
            chk("mf_after_data", sparseOutput, 0);
        end
        bnum = '{2, 2};
        bdat = '{32'h0002_0001, 32'h0004_0003};
        run_block(8'h0F, 1, 1, 1'b1, 128'h0004_0003_0002_0001, 32'h0, lat);

        // Randomized blocks against the reference model.
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            m = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            rem = 0;
            for (int i = 0; i < BL; i++) rem += int'(m[i]);
            while (rem > 0) begin
                n = (bnum.size() > 25) ? 2 : $urandom_range(0, 3);
                w = $urandom;
                bnum.push_back(n); bdat.push_back(w);
                cl = (n > MX) ? MX : n;
                rem -= (cl > rem) ? rem : cl;
            end
            run_block(m, 2, $urandom_range(0, 3), 1'b0, '0, '0, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
